// File: rtl/wfm_uart_tx_if.sv
// Bus bundle for the waveform UART serializer: sample snapshot inputs,
// start/busy/done handshake, serial line and debug index.
interface wfm_uart_tx_if #(
  parameter int SAMPLE_W  = 14,
  parameter int N_SAMPLES = 32
);
  logic [N_SAMPLES-1:0][SAMPLE_W-1:0] waveform;
  logic [15:0]                        pulse_height;
  logic                               start;
  logic                               busy;
  logic                               done;
  logic                               uart_tx;
  logic [7:0]                         cur_index;

  modport master (output waveform, pulse_height, start,
                  input  busy, done, uart_tx, cur_index);
  modport slave  (input  waveform, pulse_height, start,
                  output busy, done, uart_tx, cur_index);
endinterface

// File: rtl/wfm_uart_tx.sv
// Waveform serializer: snapshots N_SAMPLES samples plus a pulse-height word and
// streams them as 8N1 frames. Optional trailing XOR byte: WFM_UART_CHECKSUM_EN.
module wfm_uart_tx #(
  parameter int SAMPLE_W     = 14,
  parameter int N_SAMPLES    = 32,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  wfm_uart_tx_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, START_BIT, DATA_BIT, STOP_BIT, NEXT_BYTE} state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [8:0]  N_LAST   = 9'(N_SAMPLES);
`ifdef WFM_UART_CHECKSUM_EN
  localparam logic [1:0]  LAST_PH  = 2'd2;
`else
  localparam logic [1:0]  LAST_PH  = 2'd1;
`endif

  state_t                             state;
  logic [N_SAMPLES-1:0][SAMPLE_W-1:0] snap;
  logic [15:0]                        ph_reg;
  logic [8:0]                         k;
  logic [1:0]                         ph;
  logic [7:0]                         shreg;
  logic [15:0]                        baud;
  logic [2:0]                         bitcnt;
  logic                               tx_r, busy_r, done_r;
  logic [7:0]                         cur_r;
`ifdef WFM_UART_CHECKSUM_EN
  logic [7:0]                         csum;
`endif

  logic [8:0]          nk;
  logic [1:0]          nph;
  logic [SAMPLE_W-1:0] samp;
  logic [15:0]         samp_ext, in0_ext;
  logic [7:0]          nbyte;
  logic                last;

  assign bus.uart_tx   = tx_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.cur_index = cur_r;

  // Byte pointer is (sample k, phase ph); k == N_SAMPLES selects the trailer.
  always_comb begin
    nk  = k;
    nph = ph + 2'd1;
    if (ph == 2'd2) begin
      nk  = k + 9'd1;
      nph = 2'd0;
    end
    samp = '0;
    for (int i = 0; i < N_SAMPLES; i++)
      if (nk == 9'(i)) samp = snap[i];
    samp_ext = 16'(samp);
    in0_ext  = 16'(bus.waveform[0]);
    nbyte    = 8'h00;
    if (nk < N_LAST) begin
      case (nph)
        2'd0:    nbyte = samp_ext[15:8];
        2'd1:    nbyte = samp_ext[7:0];
        default: nbyte = nk[7:0];
      endcase
    end else begin
      case (nph)
        2'd0:    nbyte = ph_reg[15:8];
        2'd1:    nbyte = ph_reg[7:0];
`ifdef WFM_UART_CHECKSUM_EN
        default: nbyte = csum;
`else
        default: nbyte = 8'h00;
`endif
      endcase
    end
    last = (k == N_LAST) && (ph == LAST_PH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      ph     <= '0;
      shreg  <= '0;
      baud   <= '0;
      bitcnt <= '0;
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      cur_r  <= '0;
`ifdef WFM_UART_CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          snap   <= bus.waveform;
          ph_reg <= bus.pulse_height;
          k      <= '0;
          ph     <= '0;
          shreg  <= in0_ext[15:8];
`ifdef WFM_UART_CHECKSUM_EN
          // Cleared on snapshot, then byte 0 folded in as it is loaded.
          csum   <= in0_ext[15:8];
`endif
          cur_r  <= '0;
          baud   <= '0;
          busy_r <= 1'b1;
          tx_r   <= 1'b0;
          state  <= START_BIT;
        end
        START_BIT: if (baud == BAUD_MAX) begin
          baud   <= '0;
          bitcnt <= '0;
          tx_r   <= shreg[0];
          shreg  <= {1'b0, shreg[7:1]};
          state  <= DATA_BIT;
        end else baud <= baud + 16'd1;
        DATA_BIT: if (baud == BAUD_MAX) begin
          baud <= '0;
          if (bitcnt == 3'd7) begin
            tx_r  <= 1'b1;
            state <= STOP_BIT;
          end else begin
            bitcnt <= bitcnt + 3'd1;
            tx_r   <= shreg[0];
            shreg  <= {1'b0, shreg[7:1]};
          end
        end else baud <= baud + 16'd1;
        // Next-byte selection is folded into the stop-bit end edge so frames
        // run back-to-back; NEXT_BYTE never occupies a cycle.
        STOP_BIT: if (baud == BAUD_MAX) begin
          baud <= '0;
          if (last) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= IDLE;
          end else begin
            k     <= nk;
            ph    <= nph;
            shreg <= nbyte;
            tx_r  <= 1'b0;
            state <= START_BIT;
            if (nph == 2'd0) cur_r <= nk[7:0];
`ifdef WFM_UART_CHECKSUM_EN
            csum  <= csum ^ nbyte;
`endif
          end
        end else baud <= baud + 16'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wfm_uart_tx.sv
// Directed bench for wfm_uart_tx: default-size instance at 4 clocks/bit, a
// 9-bit x 4-sample instance at 1 clock/bit, and a checksum instance when enabled.
module tb_wfm_uart_tx;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef WFM_UART_CHECKSUM_EN
  localparam int XB = 1;
`else
  localparam int XB = 0;
`endif
  localparam int BA = 98 + XB;
  localparam int BB = 14 + XB;
  localparam int DA = 10 * BA * 4;
  localparam int DB = 10 * BB;

  wfm_uart_tx_if #(.SAMPLE_W(14), .N_SAMPLES(32)) ifa();
  wfm_uart_tx_if #(.SAMPLE_W(9),  .N_SAMPLES(4))  ifb();
  wfm_uart_tx #(.SAMPLE_W(14), .N_SAMPLES(32), .CLKS_PER_BIT(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  wfm_uart_tx #(.SAMPLE_W(9),  .N_SAMPLES(4),  .CLKS_PER_BIT(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
`ifdef WFM_UART_CHECKSUM_EN
  wfm_uart_tx_if #(.SAMPLE_W(14), .N_SAMPLES(1)) ifc();
  wfm_uart_tx #(.SAMPLE_W(14), .N_SAMPLES(1), .CLKS_PER_BIT(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
`endif

  logic [8:0] qa[$], qb[$], qc[$];
  int         dj[$];
  logic       tx0, busy0, tx_rst, busy_rst, busy_dc, tx_b2b, busy_b2b;
  logic [7:0] ci599, ci600, ci3840;

  function automatic logic get_tx(int w);
    case (w)
      0: return ifa.uart_tx;
      1: return ifb.uart_tx;
`ifdef WFM_UART_CHECKSUM_EN
      2: return ifc.uart_tx;
`endif
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic get_busy(int w);
    case (w)
      0: return ifa.busy;
      1: return ifb.busy;
`ifdef WFM_UART_CHECKSUM_EN
      2: return ifc.busy;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic get_done(int w);
    case (w)
      0: return ifa.done;
      1: return ifb.done;
`ifdef WFM_UART_CHECKSUM_EN
      2: return ifc.done;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: ifa.start = v;
      1: ifb.start = v;
`ifdef WFM_UART_CHECKSUM_EN
      2: ifc.start = v;
`endif
      default: ;
    endcase
  endtask

  task automatic push(input int w, input logic [8:0] v);
    case (w)
      0: qa.push_back(v);
      1: qb.push_back(v);
      default: qc.push_back(v);
    endcase
  endtask

  function automatic logic [8:0] qget(int w, int i);
    if (w == 0) return (i < qa.size()) ? qa[i] : 9'bx;
    if (w == 1) return (i < qb.size()) ? qb[i] : 9'bx;
    return (i < qc.size()) ? qc[i] : 9'bx;
  endfunction

  // Frame receiver: stores {stop_bit, data} for every frame seen on the line.
  task automatic mon(input int w, input int c);
    logic [7:0] d;
    logic       sb;
    forever begin
      @(negedge clk);
      if (!rst && get_tx(w) === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (c) @(negedge clk);
          d[i] = get_tx(w);
        end
        repeat (c) @(negedge clk);
        sb = get_tx(w);
        repeat (c - 1) @(negedge clk);
        push(w, {sb, d});
      end
    end
  endtask

  initial mon(0, 4);
  initial mon(1, 1);
`ifdef WFM_UART_CHECKSUM_EN
  initial mon(2, 1);
`endif

  // Reference byte stream for sample[k] = (base + inc*k) masked to w bits.
  function automatic logic [7:0] exp_byte(int p, int n, int w, int base, int inc, logic [15:0] phw);
    logic [15:0] s;
    logic [7:0]  x;
    int          kk;
    if (p < 3 * n) begin
      kk = p / 3;
      s  = 16'((base + inc * kk) & ((1 << w) - 1));
      case (p % 3)
        0:       return s[15:8];
        1:       return s[7:0];
        default: return 8'(kk);
      endcase
    end
    if (p == 3 * n)     return phw[15:8];
    if (p == 3 * n + 1) return phw[7:0];
    x = 8'h00;
    for (int i = 0; i < 3 * n + 2; i++) x = x ^ exp_byte(i, n, w, base, inc, phw);
    return x;
  endfunction

  function automatic int count_bad(int w, int nb, int n, int sw, int base, int inc, logic [15:0] phw, int reps);
    int bad = 0;
    for (int i = 0; i < nb * reps; i++)
      if (qget(w, i) !== {1'b1, exp_byte(i % nb, n, sw, base, inc, phw)}) bad++;
    return bad;
  endfunction

  task automatic set_wf_a(input int base, input logic [15:0] phw);
    for (int k = 0; k < 32; k++) ifa.waveform[k] = 14'(base + k);
    ifa.pulse_height = phw;
  endtask

  // mode: 0 plain, 1 change inputs after snapshot, 2 start pokes while busy,
  // 3 reset mid-byte 40, 4 start held high across done.
  task automatic run(input int w, input int mode, input int limit,
                     output int done_j, output int busy_n, output int ndone);
    done_j = -1; busy_n = 0; ndone = 0;
    dj.delete();
    @(negedge clk); set_start(w, 1'b1);
    @(negedge clk); if (mode != 4) set_start(w, 1'b0);
    for (int j = 0; j < limit; j++) begin
      if (get_busy(w) === 1'b1) busy_n++;
      if (get_done(w) === 1'b1) begin
        ndone++; dj.push_back(j);
        if (done_j < 0) done_j = j;
      end
      if (j == 0)    begin tx0 = get_tx(w); busy0 = get_busy(w); end
      if (j == 599)  ci599  = ifa.cur_index;
      if (j == 600)  ci600  = ifa.cur_index;
      if (j == 3840) ci3840 = ifa.cur_index;
      if (mode == 1 && j == 0) begin
        for (int k = 0; k < 32; k++) ifa.waveform[k] = 14'h3FFF;
        ifa.pulse_height = 16'hFFFF;
      end
      if (mode == 2 && (j == 100 || j == 2000)) set_start(w, 1'b1);
      if (mode == 2 && (j == 101 || j == 2001)) set_start(w, 1'b0);
      if (mode == 3 && j == 1610) rst = 1'b1;
      if (mode == 3 && j == 1611) begin tx_rst = get_tx(w); busy_rst = get_busy(w); rst = 1'b0; end
      if (mode == 4 && j == DA) busy_dc = get_busy(w);
      if (mode == 4 && j == DA + 1) begin tx_b2b = get_tx(w); busy_b2b = get_busy(w); set_start(w, 1'b0); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifa.start = 1'b1;
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifa.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", ifa.uart_tx); end
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_with_start: got %b expected 0", ifa.busy); end
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", ifa.done); end
    checks++; if (ifa.cur_index !== 8'd0) begin errors++; $display("FAIL reset_cur_index: got %0d expected 0", ifa.cur_index); end
    checks++; if (ifb.uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx_b: got %b expected 1", ifb.uart_tx); end
    ifa.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_main();
    int d, b, n, bad;
    set_wf_a(16'h2000, 16'hBEEF);
    qa.delete();
    run(0, 0, DA + 30, d, b, n);
    checks++; if (tx0 !== 1'b0 || busy0 !== 1'b1) begin errors++; $display("FAIL main_first_cycle: got tx=%b busy=%b expected tx=0 busy=1", tx0, busy0); end
    checks++; if (d !== DA) begin errors++; $display("FAIL main_done_cycle: got %0d expected %0d", d, DA); end
    checks++; if (b !== DA) begin errors++; $display("FAIL main_busy_cycles: got %0d expected %0d", b, DA); end
    checks++; if (n !== 1) begin errors++; $display("FAIL main_done_pulses: got %0d expected 1", n); end
    checks++; if (qa.size() !== BA) begin errors++; $display("FAIL main_frames: got %0d expected %0d", qa.size(), BA); end
    checks++; if (qget(0, 0) !== 9'h120) begin errors++; $display("FAIL main_frame0: got %h expected 120", qget(0, 0)); end
    checks++; if (qget(0, 1) !== 9'h100) begin errors++; $display("FAIL main_frame1: got %h expected 100", qget(0, 1)); end
    checks++; if (qget(0, 2) !== 9'h100) begin errors++; $display("FAIL main_frame2: got %h expected 100", qget(0, 2)); end
    checks++; if (qget(0, 95) !== 9'h11F) begin errors++; $display("FAIL main_frame95: got %h expected 11f", qget(0, 95)); end
    checks++; if (qget(0, 96) !== 9'h1BE) begin errors++; $display("FAIL main_frame96: got %h expected 1be", qget(0, 96)); end
    checks++; if (qget(0, 97) !== 9'h1EF) begin errors++; $display("FAIL main_frame97: got %h expected 1ef", qget(0, 97)); end
    checks++; if (ci599 !== 8'd4 || ci600 !== 8'd5) begin errors++; $display("FAIL main_cur_index: got %0d/%0d expected 4/5", ci599, ci600); end
    checks++; if (ci3840 !== 8'd32) begin errors++; $display("FAIL main_cur_index_trailer: got %0d expected 32", ci3840); end
    bad = count_bad(0, BA, 32, 14, 16'h2000, 1, 16'hBEEF, 1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL main_all_bytes: got %0d bad frames expected 0", bad); end
  endtask

  task automatic test_snapshot();
    int d, b, n, bad;
    set_wf_a(16'h2000, 16'hBEEF);
    qa.delete();
    run(0, 1, DA + 30, d, b, n);
    bad = count_bad(0, BA, 32, 14, 16'h2000, 1, 16'hBEEF, 1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL snapshot_bytes: got %0d bad frames expected 0", bad); end
    checks++; if (d !== DA) begin errors++; $display("FAIL snapshot_done: got %0d expected %0d", d, DA); end
    set_wf_a(16'h2000, 16'hBEEF);
  endtask

  task automatic test_start_while_busy();
    int d, b, n, bad;
    qa.delete();
    run(0, 2, DA + 60, d, b, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL busy_start_done_pulses: got %0d expected 1", n); end
    checks++; if (b !== DA) begin errors++; $display("FAIL busy_start_busy_cycles: got %0d expected %0d", b, DA); end
    checks++; if (qa.size() !== BA) begin errors++; $display("FAIL busy_start_frames: got %0d expected %0d", qa.size(), BA); end
    bad = count_bad(0, BA, 32, 14, 16'h2000, 1, 16'hBEEF, 1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL busy_start_bytes: got %0d bad frames expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int d, b, n, bad;
    qa.delete();
    run(0, 3, 1711, d, b, n);
    checks++; if (tx_rst !== 1'b1 || busy_rst !== 1'b0) begin errors++; $display("FAIL midrst_state: got tx=%b busy=%b expected tx=1 busy=0", tx_rst, busy_rst); end
    checks++; if (n !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses expected 0", n); end
    qa.delete();
    run(0, 0, DA + 30, d, b, n);
    checks++; if (d !== DA) begin errors++; $display("FAIL midrst_rerun_done: got %0d expected %0d", d, DA); end
    checks++; if (qa.size() !== BA) begin errors++; $display("FAIL midrst_rerun_frames: got %0d expected %0d", qa.size(), BA); end
    bad = count_bad(0, BA, 32, 14, 16'h2000, 1, 16'hBEEF, 1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_rerun_bytes: got %0d bad frames expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    int d, b, n, bad, d2;
    qa.delete();
    run(0, 4, 2 * DA + 40, d, b, n);
    d2 = (dj.size() > 1) ? dj[1] : -1;
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 2", n); end
    checks++; if (d !== DA || d2 !== 2 * DA + 1) begin errors++; $display("FAIL b2b_done_cycles: got %0d/%0d expected %0d/%0d", d, d2, DA, 2 * DA + 1); end
    checks++; if (busy_dc !== 1'b0) begin errors++; $display("FAIL b2b_busy_on_done: got %b expected 0", busy_dc); end
    checks++; if (tx_b2b !== 1'b0 || busy_b2b !== 1'b1) begin errors++; $display("FAIL b2b_restart: got tx=%b busy=%b expected tx=0 busy=1", tx_b2b, busy_b2b); end
    bad = count_bad(0, BA, 32, 14, 16'h2000, 1, 16'hBEEF, 2);
    checks++; if (bad !== 0 || qa.size() !== 2 * BA) begin errors++; $display("FAIL b2b_bytes: got %0d bad of %0d frames expected 0 of %0d", bad, qa.size(), 2 * BA); end
  endtask

  task automatic test_small();
    int d, b, n, bad;
    for (int k = 0; k < 4; k++) ifb.waveform[k] = 9'h1FF;
    ifb.pulse_height = 16'h1234;
    qb.delete();
    run(1, 0, DB + 20, d, b, n);
    checks++; if (d !== DB || b !== DB) begin errors++; $display("FAIL small_timing: got done=%0d busy=%0d expected %0d", d, b, DB); end
    checks++; if (qb.size() !== BB) begin errors++; $display("FAIL small_frames: got %0d expected %0d", qb.size(), BB); end
    checks++; if (qget(1, 0) !== 9'h101 || qget(1, 1) !== 9'h1FF) begin errors++; $display("FAIL small_sample0: got %h %h expected 101 1ff", qget(1, 0), qget(1, 1)); end
    checks++; if (qget(1, 11) !== 9'h103) begin errors++; $display("FAIL small_index3: got %h expected 103", qget(1, 11)); end
    checks++; if (qget(1, 12) !== 9'h112 || qget(1, 13) !== 9'h134) begin errors++; $display("FAIL small_trailer: got %h %h expected 112 134", qget(1, 12), qget(1, 13)); end
    bad = count_bad(1, BB, 4, 9, 16'h1FF, 0, 16'h1234, 1);
    checks++; if (bad !== 0) begin errors++; $display("FAIL small_bytes: got %0d bad frames expected 0", bad); end
  endtask

`ifdef WFM_UART_CHECKSUM_EN
  task automatic test_checksum();
    int d, b, n;
    logic [7:0] want [6];
    // 0A ^ BC ^ 00 ^ 12 ^ 34 = 90
    want = '{8'h0A, 8'hBC, 8'h00, 8'h12, 8'h34, 8'h90};
    ifc.waveform[0] = 14'h0ABC;
    ifc.pulse_height = 16'h1234;
    qc.delete();
    run(2, 0, 80, d, b, n);
    checks++; if (d !== 60 || qc.size() !== 6) begin errors++; $display("FAIL csum_len: got done=%0d frames=%0d expected 60/6", d, qc.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (qget(2, i) !== {1'b1, want[i]}) begin errors++; $display("FAIL csum_byte%0d: got %h expected %h", i, qget(2, i), {1'b1, want[i]}); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    set_wf_a(0, 16'h0000);
    for (int k = 0; k < 4; k++) ifb.waveform[k] = 9'h000;
    ifb.pulse_height = 16'h0000;
`ifdef WFM_UART_CHECKSUM_EN
    ifc.start = 1'b0; ifc.waveform = '0; ifc.pulse_height = 16'h0000;
`endif
    test_reset();
    test_main();
    test_snapshot();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_small();
`ifdef WFM_UART_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
